// File: rtl/cmp_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmp_share_arbiter
// Brief    : Round-robin sequencer sharing one external magnitude comparator
//            among N_REQ requesters. Optional consistency checker enabled by
//            the macro CMP_SHARE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cmp_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [WIDTH-1:0]       cmp_a,
    output logic [WIDTH-1:0]       cmp_b,
    input  logic                   cmp_lt,
    input  logic                   cmp_gt,
    input  logic                   cmp_eq,
    output logic [N_REQ-1:0]       ack,
    output logic                   res_lt,
    output logic                   res_gt,
    output logic                   res_eq,
    output logic                   busy,
    output logic                   cmp_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT  = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_gnt_id;
    logic [IDX_W-1:0] w_pick;
    logic             w_found;
    int               w_idx;

    // First asserted request at or above the round-robin pointer, wrapping.
    always_comb begin
        w_pick  = r_rr_ptr;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            cmp_a    <= '0;
            cmp_b    <= '0;
            ack      <= '0;
            res_lt   <= 1'b0;
            res_gt   <= 1'b0;
            res_eq   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            ack <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt_id <= w_pick;
                        cmp_a    <= op_a[int'(w_pick)*WIDTH +: WIDTH];
                        cmp_b    <= op_b[int'(w_pick)*WIDTH +: WIDTH];
                        busy     <= 1'b1;
                        r_state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    res_lt   <= cmp_lt;
                    res_gt   <= cmp_gt;
                    res_eq   <= cmp_eq;
                    ack      <= N_REQ'(1) << r_gnt_id;
                    r_rr_ptr <= (r_gnt_id == C_LAST_IDX) ? '0 : r_gnt_id + 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CMP_SHARE_CHECK_EN
    logic w_inconsistent;

    // The true relation is always one-hot, so any mismatch also catches
    // non-one-hot comparator outputs.
    assign w_inconsistent = ({cmp_lt, cmp_gt, cmp_eq} !=
                             {(cmp_a < cmp_b), (cmp_a > cmp_b), (cmp_a == cmp_b)});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_err <= 1'b0;
        end else if (r_state == S_SAMPLE && w_inconsistent) begin
            cmp_err <= 1'b1;
        end
    end
`else
    assign cmp_err = 1'b0;
`endif

endmodule
`default_nettype wire
